// File: rtl/mig_req_arb_if.sv
// Bundle of requester A/B ports, MIG request/write-data/read-data queue ports
// and the shared read-return bus seen by the two-requester MIG arbiter.
interface mig_req_arb_if;
  logic         a_req;
  logic         a_rd_bwt;
  logic [31:0]  a_addr;
  logic [127:0] a_wdata;
  logic [15:0]  a_wmask;
  logic         a_ack;

  logic         b_req;
  logic         b_rd_bwt;
  logic [31:0]  b_addr;
  logic [127:0] b_wdata;
  logic [15:0]  b_wmask;
  logic         b_ack;

  logic         req_wen;
  logic [31:0]  req_qwaddr;
  logic         req_qwbwt;
  logic         req_wqfull;

  logic         wdq_wen;
  logic [143:0] wdq_mask_wdata;
  logic         wdq_wqfull;

  logic         rdq_rnext;
  logic         rdq_rqempty;
  logic [127:0] rdq_rdata;

  logic         a_rvalid;
  logic         b_rvalid;
  logic [127:0] rdata;

  // Arbiter side
  modport master (
    input  a_req, a_rd_bwt, a_addr, a_wdata, a_wmask,
    input  b_req, b_rd_bwt, b_addr, b_wdata, b_wmask,
    input  req_wqfull, wdq_wqfull, rdq_rqempty, rdq_rdata,
    output a_ack, b_ack,
    output req_wen, req_qwaddr, req_qwbwt,
    output wdq_wen, wdq_mask_wdata,
    output rdq_rnext,
    output a_rvalid, b_rvalid, rdata
  );

  // Requester / queue environment side
  modport slave (
    output a_req, a_rd_bwt, a_addr, a_wdata, a_wmask,
    output b_req, b_rd_bwt, b_addr, b_wdata, b_wmask,
    output req_wqfull, wdq_wqfull, rdq_rqempty, rdq_rdata,
    input  a_ack, b_ack,
    input  req_wen, req_qwaddr, req_qwbwt,
    input  wdq_wen, wdq_mask_wdata,
    input  rdq_rnext,
    input  a_rvalid, b_rvalid, rdata
  );
endinterface

// File: rtl/mig_req_arb.sv
// Round-robin arbiter of two requesters onto the MIG request/write-data queues,
// with an owner FIFO that steers in-order read returns back to A or B.
module mig_req_arb #(
  parameter int TAG_DEPTH = 8,
  parameter int TAG_AW    = 3
) (
  input  logic mclk,
  input  logic mrst_n,
  mig_req_arb_if.master bus
);

  localparam logic [TAG_AW:0] L_DEPTH = (TAG_AW + 1)'(TAG_DEPTH);

  logic                 r_last_gnt;
  logic [TAG_AW-1:0]    r_wptr;
  logic [TAG_AW-1:0]    r_rptr;
  logic [TAG_AW:0]      r_count;
  logic [TAG_DEPTH-1:0] r_own;
  logic                 r_a_rvalid;
  logic                 r_b_rvalid;
  logic [127:0]         r_rdata;

  logic w_any;
  logic w_sel_b;
  logic w_sel_rd;
  logic w_full;
  logic w_empty;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_pop_owner;

  // With both pending, B wins only when A was granted last.
  assign w_any    = bus.a_req | bus.b_req;
  assign w_sel_b  = bus.b_req & (~bus.a_req | ~r_last_gnt);
  assign w_sel_rd = w_sel_b ? bus.b_rd_bwt : bus.a_rd_bwt;

  assign w_full   = (r_count == L_DEPTH);
  assign w_empty  = (r_count == '0);

  // A stalled selection holds; it never falls through to the other requester.
  assign w_accept = mrst_n & w_any & ~bus.req_wqfull &
                    (w_sel_rd ? ~w_full : ~bus.wdq_wqfull);
  assign w_push   = w_accept & w_sel_rd;
  assign w_pop    = mrst_n & ~bus.rdq_rqempty & ~w_empty;
  assign w_pop_owner = r_own[r_rptr];

  assign bus.a_ack          = w_accept & ~w_sel_b;
  assign bus.b_ack          = w_accept & w_sel_b;
  assign bus.req_wen        = w_accept;
  assign bus.req_qwaddr     = w_sel_b ? bus.b_addr : bus.a_addr;
  assign bus.req_qwbwt      = w_sel_rd;
  assign bus.wdq_wen        = w_accept & ~w_sel_rd;
  assign bus.wdq_mask_wdata = w_sel_b ? {bus.b_wmask, bus.b_wdata}
                                      : {bus.a_wmask, bus.a_wdata};
  assign bus.rdq_rnext      = w_pop;

  assign bus.a_rvalid = r_a_rvalid;
  assign bus.b_rvalid = r_b_rvalid;
  assign bus.rdata    = r_rdata;

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      r_last_gnt <= 1'b1;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_rdata    <= '0;
    end else begin
      if (w_accept) begin
        r_last_gnt <= w_sel_b;
      end
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr  <= r_rptr + 1'b1;
        r_rdata <= bus.rdq_rdata;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_a_rvalid <= w_pop & ~w_pop_owner;
      r_b_rvalid <= w_pop & w_pop_owner;
    end
  end

  // Owner storage needs no reset: only entries between the pointers are read.
  always_ff @(posedge mclk) begin
    if (w_push) begin
      r_own[r_wptr] <= w_sel_b;
    end
  end

endmodule

// File: tb/tb_mig_req_arb.sv
// Randomized + directed scoreboard bench for mig_req_arb against a queue-based
// reference of the arbitration, owner-FIFO and read-return rules.
module tb_mig_req_arb;
  localparam int TAG_DEPTH = 8;

  typedef struct {
    int           cyc;
    bit           a_ack, b_ack, req_wen, wdq_wen, rnext, bwt;
    logic [31:0]  addr;
    logic [143:0] wd;
  } exp_t;

  typedef struct {
    int           cyc;
    bit           who;
    logic [127:0] data;
  } rd_t;

  logic mclk = 1'b0;
  logic mrst_n;
  int   n_err = 0;
  int   n_checks = 0;
  bit   mon_en = 1'b0;

  mig_req_arb_if bus ();

  mig_req_arb #(.TAG_DEPTH(TAG_DEPTH), .TAG_AW(3)) dut (
    .mclk   (mclk),
    .mrst_n (mrst_n),
    .bus    (bus.master)
  );

  always #5 mclk = ~mclk;

  // Environment state (requesters and the read-data queue contents)
  bit           pend [2];
  bit           rd   [2];
  logic [31:0]  addr [2];
  logic [127:0] wd   [2];
  logic [15:0]  wm   [2];
  bit           req_full = 1'b0;
  bit           wdq_full = 1'b0;
  logic [127:0] rdq_env [$];

  // Reference model
  bit   m_last = 1'b1;
  bit   m_own [$];
  int   cyc = 0;
  exp_t exp_q [$];
  rd_t  exp_rd [$];

  bit           act_ack [2];
  bit           act_rnext;
  bit           got_who [$];
  logic [127:0] got_data [$];
  logic [127:0] last_rdata = '0;

  task automatic chk(string name, logic [143:0] act, logic [143:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_inputs();
    bus.a_req       = pend[0];
    bus.a_rd_bwt    = rd[0];
    bus.a_addr      = addr[0];
    bus.a_wdata     = wd[0];
    bus.a_wmask     = wm[0];
    bus.b_req       = pend[1];
    bus.b_rd_bwt    = rd[1];
    bus.b_addr      = addr[1];
    bus.b_wdata     = wd[1];
    bus.b_wmask     = wm[1];
    bus.req_wqfull  = req_full;
    bus.wdq_wqfull  = wdq_full;
    bus.rdq_rqempty = (rdq_env.size() == 0);
    bus.rdq_rdata   = (rdq_env.size() > 0) ? rdq_env[0] : '0;
  endtask

  task automatic new_req(bit who, bit is_rd);
    pend[who] = 1'b1;
    rd[who]   = is_rd;
    addr[who] = $urandom & 32'hFFFF_FFF0;
    wd[who]   = {$urandom, $urandom, $urandom, $urandom};
    wm[who]   = 16'($urandom);
  endtask

  // One clock: drive, predict, then apply the DUT's handshakes to the environment.
  task automatic step();
    exp_t e;
    rd_t  r;
    bit   who, is_rd, ok, pop;
    drive_inputs();
    if (pend[0] && pend[1]) who = ~m_last;
    else                    who = pend[1];
    is_rd = rd[who];
    ok  = (pend[0] || pend[1]) && !req_full &&
          (is_rd ? (m_own.size() < TAG_DEPTH) : !wdq_full);
    pop = (rdq_env.size() > 0) && (m_own.size() > 0);
    e.cyc = cyc;
    e.a_ack = ok && !who;
    e.b_ack = ok && who;
    e.req_wen = ok;
    e.wdq_wen = ok && !is_rd;
    e.rnext = pop;
    e.bwt = is_rd;
    e.addr = addr[who];
    e.wd = {wm[who], wd[who]};
    exp_q.push_back(e);
    if (pop) begin
      r.cyc = cyc + 1;
      r.who = m_own[0];
      r.data = rdq_env[0];
      exp_rd.push_back(r);
      void'(m_own.pop_front());
    end
    if (ok && is_rd) m_own.push_back(who);
    if (ok) m_last = who;
    #3;
    act_ack[0] = bus.a_ack;
    act_ack[1] = bus.b_ack;
    act_rnext  = bus.rdq_rnext;
    @(posedge mclk);
    #1;
    if (act_ack[0]) pend[0] = 1'b0;
    if (act_ack[1]) pend[1] = 1'b0;
    if (act_rnext && rdq_env.size() > 0) void'(rdq_env.pop_front());
    cyc++;
  endtask

  task automatic run_until_idle(int limit);
    int n = 0;
    while ((pend[0] || pend[1]) && n < limit) begin
      step();
      n++;
    end
    chk("idle_timeout", {pend[0], pend[1]}, 2'b00);
  endtask

  // Monitor: compares DUT outputs against the queued predictions each cycle.
  always @(negedge mclk) begin
    exp_t e;
    rd_t  r;
    if (!mrst_n) begin
      last_rdata = '0;
    end else if (mon_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ctrl{aack,back,reqwen,wdqwen,rnext}",
          {bus.a_ack, bus.b_ack, bus.req_wen, bus.wdq_wen, bus.rdq_rnext},
          {e.a_ack, e.b_ack, e.req_wen, e.wdq_wen, e.rnext});
      if (e.req_wen) begin
        chk("req_qwaddr", bus.req_qwaddr, e.addr);
        chk("req_qwbwt", bus.req_qwbwt, e.bwt);
      end
      if (e.wdq_wen) chk("wdq_mask_wdata", bus.wdq_mask_wdata, e.wd);
      chk("rvalid_onehot", bus.a_rvalid & bus.b_rvalid, 1'b0);
      if (bus.a_rvalid || bus.b_rvalid) begin
        if (exp_rd.size() == 0) begin
          chk("rvalid_spurious", bus.a_rvalid | bus.b_rvalid, 1'b0);
        end else begin
          r = exp_rd.pop_front();
          chk("rvalid_cycle", e.cyc, r.cyc);
          chk("rvalid_owner_b", bus.b_rvalid, r.who);
          chk("rdata", bus.rdata, r.data);
          last_rdata = r.data;
          got_who.push_back(bus.b_rvalid);
          got_data.push_back(bus.rdata);
        end
      end else begin
        if (exp_rd.size() > 0 && exp_rd[0].cyc <= e.cyc) begin
          chk("rvalid_present", bus.a_rvalid | bus.b_rvalid, 1'b1);
          void'(exp_rd.pop_front());
        end
        chk("rdata_hold", bus.rdata, last_rdata);
      end
    end
  end

  localparam logic [127:0] D0 = 128'hD0D0_0000_1111_2222_3333_4444_5555_0000;
  localparam logic [127:0] D1 = 128'hD1D1_0000_AAAA_BBBB_CCCC_DDDD_EEEE_0001;
  localparam logic [127:0] D2 = 128'hD2D2_0000_1234_5678_9ABC_DEF0_0F0F_0002;

  initial begin
    int base;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; rd[i] = 1'b0; addr[i] = '0; wd[i] = '0; wm[i] = '0;
    end

    // Asynchronous reset with requests and read data present
    mrst_n = 1'b1;
    new_req(0, 0);
    new_req(1, 0);
    rdq_env.push_back(D0);
    drive_inputs();
    #1 mrst_n = 1'b0;
    #1;
    chk("rst_acks", {bus.a_ack, bus.b_ack}, 2'b00);
    chk("rst_wen", {bus.req_wen, bus.wdq_wen, bus.rdq_rnext}, 3'b000);
    chk("rst_rvalid", {bus.a_rvalid, bus.b_rvalid}, 2'b00);
    chk("rst_rdata", bus.rdata, 128'h0);
    repeat (2) @(posedge mclk);
    #1;
    chk("rst_hold_acks", {bus.a_ack, bus.b_ack, bus.req_wen, bus.wdq_wen}, 4'b0000);
    chk("rst_hold_rnext", bus.rdq_rnext, 1'b0);
    rdq_env.delete();
    drive_inputs();
    mrst_n = 1'b1;
    mon_en = 1'b1;

    // Continuous writes from both: A,B,A,B... starting with A
    for (int i = 0; i < 8; i++) begin
      if (!pend[0]) new_req(0, 0);
      if (!pend[1]) new_req(1, 0);
      step();
      chk("rr_a_ack", act_ack[0], 1'((i % 2) == 0));
      chk("rr_b_ack", act_ack[1], 1'((i % 2) == 1));
    end
    run_until_idle(10);

    // Write stalled by a full write-data queue
    new_req(0, 0);
    wdq_full = 1'b1;
    repeat (5) step();
    chk("wdqfull_hold", pend[0], 1'b1);
    wdq_full = 1'b0;
    step();
    chk("wdqfull_release", pend[0], 1'b0);

    // Fill the owner FIFO with A reads, then pop-at-full with a read pending
    for (int i = 0; i < 8; i++) begin
      new_req(0, 1);
      step();
      chk("rd_fill_ack", pend[0], 1'b0);
    end
    new_req(0, 1);
    repeat (3) step();
    chk("rd_9th_stall", pend[0], 1'b1);
    rdq_env.push_back({$urandom, $urandom, $urandom, $urandom});
    step();
    chk("full_pop_no_ack", pend[0], 1'b1);
    step();
    chk("ack_after_pop", pend[0], 1'b0);
    for (int i = 0; i < 8; i++) rdq_env.push_back({$urandom, $urandom, $urandom, $urandom});
    repeat (12) step();

    // Ordered interleaved returns
    base = got_who.size();
    new_req(0, 1); addr[0] = 32'h100; step();
    new_req(1, 1); addr[1] = 32'h200; step();
    new_req(0, 1); addr[0] = 32'h300; step();
    chk("order_acked", {pend[0], pend[1]}, 2'b00);
    rdq_env.push_back(D0);
    rdq_env.push_back(D1);
    rdq_env.push_back(D2);
    repeat (6) step();
    chk("order_count", got_who.size() - base, 3);
    if (got_who.size() - base >= 3) begin
      chk("order_who", {got_who[base], got_who[base+1], got_who[base+2]}, 3'b010);
      chk("order_d0", got_data[base], D0);
      chk("order_d1", got_data[base+1], D1);
      chk("order_d2", got_data[base+2], D2);
    end

    // Reset with reads outstanding and a return in flight
    for (int i = 0; i < 4; i++) begin
      new_req(0, 1);
      step();
    end
    rdq_env.push_back(128'h5A5A_5A5A_A5A5_A5A5_5A5A_5A5A_A5A5_A5A5);
    step();
    #1;
    mon_en = 1'b0;
    mrst_n = 1'b0;
    new_req(0, 0);
    new_req(1, 0);
    drive_inputs();
    #1;
    chk("midrst_rvalid", {bus.a_rvalid, bus.b_rvalid}, 2'b00);
    chk("midrst_rdata", bus.rdata, 128'h0);
    chk("midrst_acks", {bus.a_ack, bus.b_ack, bus.req_wen}, 3'b000);
    m_own.delete();
    m_last = 1'b1;
    exp_q.delete();
    exp_rd.delete();
    rdq_env.delete();
    @(posedge mclk);
    #1;
    mrst_n = 1'b1;
    mon_en = 1'b1;
    step();
    chk("post_rst_first_A", {act_ack[0], act_ack[1]}, 2'b10);
    run_until_idle(10);
    for (int i = 0; i < 8; i++) begin
      new_req(0, 1);
      step();
      chk("post_rst_fill", pend[0], 1'b0);
    end
    new_req(0, 1);
    step();
    chk("post_rst_9th_stall", pend[0], 1'b1);
    for (int i = 0; i < 9; i++) rdq_env.push_back({$urandom, $urandom, $urandom, $urandom});
    repeat (14) step();
    chk("post_rst_9th_acked", pend[0], 1'b0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if (!pend[0] && ($urandom % 4) != 0) new_req(0, 1'($urandom % 2));
      if (!pend[1] && ($urandom % 4) != 0) new_req(1, 1'($urandom % 2));
      req_full = (($urandom % 8) == 0);
      wdq_full = (($urandom % 6) == 0);
      if (($urandom % 3) == 0 && rdq_env.size() < 16)
        rdq_env.push_back({$urandom, $urandom, $urandom, $urandom});
      step();
    end

    // Drain
    req_full = 1'b0;
    wdq_full = 1'b0;
    run_until_idle(20);
    for (int i = rdq_env.size(); i < m_own.size(); i++)
      rdq_env.push_back({$urandom, $urandom, $urandom, $urandom});
    repeat (30) step();
    chk("drain_returns_left", exp_rd.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
